mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The module SHALL be clocked by `clock`, and `reset` SHALL be synchronous and active-high.
REQ-002 The module SHALL have the following ports, in this order:
- clock  in  1  rising-edge clock
- reset  in  1  sync active-high reset
- mem_instruction  in  32  instruction in MEM; 0 = bubble
- mem_shouldWriteRegister  in  1  instruction writes a register
- mem_registerWriteAddress  in  5  destination register
- mem_shouldWriteMemoryElseAluOutputToRegister  in  1  1 = load data to register, 0 = ALU result
- mem_aluOutput  in  32  effective address or ALU result
- mem_shouldWriteMemory  in  1  store request
- mem_registerRtOrZero  in  32  store data
- dmem_req  out  1  data-bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  32  word address; bits[1:0] always 0
- dmem_wdata  out  32  store data
- dmem_ack  in  1  bus completes access this cycle
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- stall  out  1  hold IF/ID/EX and EX/MEM registers
- wb_instruction  out  32  registered instruction for WB
- wb_shouldWriteRegister  out  1  registered write enable
- wb_registerWriteAddress  out  5  registered destination
- wb_registerWriteData  out  32  registered write-back value
- err_misaligned  out  1  sticky: misaligned access seen
- err_timeout  out  1  sticky: bus timeout seen
REQ-003 The module SHALL use parameter TIMEOUT_CYCLES, default 255, as the maximum number of WAIT cycles before abort.

Function
REQ-004 The module SHALL define load = mem_shouldWriteRegister & mem_shouldWriteMemoryElseAluOutputToRegister, store = mem_shouldWriteMemory, access = load|store, and misaligned = access & (mem_aluOutput[1:0] != 0).
REQ-005 The FSM SHALL have two states: IDLE (no outstanding access) and WAIT (request outstanding).
REQ-006 dmem_req SHALL be combinational: asserted in IDLE when access & ~misaligned, and in WAIT always; dmem_we = store, dmem_addr = {mem_aluOutput[31:2],2'b00}, dmem_wdata = mem_registerRtOrZero.
REQ-007 stall SHALL equal dmem_req & ~dmem_ack, so a zero-wait bus (ack in the request cycle) causes no stall.
REQ-008 Transitions SHALL be: IDLE->WAIT when dmem_req & ~dmem_ack; WAIT->IDLE on dmem_ack; WAIT->IDLE when the wait counter reaches TIMEOUT_CYCLES (abort).
REQ-009 The 8-bit wait counter SHALL clear on entry to WAIT, increment each WAIT cycle without ack, and saturate without wrapping.
REQ-010 On timeout the module SHALL deassert stall in that cycle, set err_timeout, and retire the instruction with wb_shouldWriteRegister=0.
REQ-011 A misaligned access SHALL issue no bus request and cause no stall, SHALL set err_misaligned, and SHALL retire with wb_shouldWriteRegister=0.
REQ-012 Each cycle with stall=0, the WB register SHALL load wb_instruction=mem_instruction, wb_shouldWriteRegister=mem_shouldWriteRegister (subject to REQ-010/011), wb_registerWriteAddress=mem_registerWriteAddress, and wb_registerWriteData = load ? dmem_rdata : mem_aluOutput.
REQ-013 Each cycle with stall=1, the WB register SHALL load a bubble: all wb_* outputs 0.
REQ-014 Load-to-WB latency SHALL be 1 cycle after the ack cycle; non-access instructions SHALL take exactly 1 cycle.
REQ-015 The MEM inputs SHALL be treated as stable while stall=1; an ack arriving in IDLE with dmem_req=0 SHALL be ignored.
REQ-016 Error flags SHALL be sticky and clear only on reset.

Reset
REQ-017 On reset the FSM SHALL go to IDLE, the counter SHALL be 0, all wb_* outputs SHALL be 0, and both error flags SHALL be 0.
REQ-018 Reset asserted in WAIT SHALL abandon the access; dmem_req, and therefore stall, SHALL be 0 in the cycle after reset when the EX/MEM register holds a bubble.

Structure
REQ-019 The shared package mem_pkg SHALL hold the state typedef (IDLE, WAIT), the TIMEOUT_CYCLES default, and the width constants 32 and 5.
REQ-020 The WB pipeline register SHALL be a sub-module named mem_wb_register, with a bubble input driven by stall; the FSM, counter and bus logic SHALL stay at top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ALU op (aluOutput=0x1234, rd=5, write=1), no access -> next cycle wb_registerWriteData=0x1234, wb_registerWriteAddress=5, stall never 1.
- Load addr 0x100, ack same cycle with rdata=0xDEADBEEF -> no stall; next cycle wb_registerWriteData=0xDEADBEEF.
- Store addr 0x204 data 0xCAFE, ack after 3 cycles -> dmem_we=1 and stall=1 for 3 cycles, WB bubbles for 3 cycles, then wb_shouldWriteRegister=0.
- Load addr 0x102 -> dmem_req=0, err_misaligned=1, wb_shouldWriteRegister=0.
- Load with no ack -> stall for 255 cycles, then err_timeout=1, stall=0, wb_shouldWriteRegister=0.
- Reset asserted during WAIT -> next cycle state IDLE, all wb_*=0, flags 0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MEM access stage
package mem_pkg;
    localparam int DATA_WIDTH             = 32;
    localparam int REG_ADDR_WIDTH         = 5;
    localparam int WAIT_COUNT_WIDTH       = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/mem_wb_register.sv
// rtl/mem_wb_register.sv - MEM/WB pipeline register; loads a bubble when told to
module mem_wb_register
    import mem_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      bubble,
    input  logic [DATA_WIDTH-1:0]     instruction,
    input  logic                      write_register,
    input  logic [REG_ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH-1:0]     wb_instruction,
    output logic                      wb_write_register,
    output logic [REG_ADDR_WIDTH-1:0] wb_write_address,
    output logic [DATA_WIDTH-1:0]     wb_write_data
);
    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            wb_instruction    <= '0;
            wb_write_register <= 1'b0;
            wb_write_address  <= '0;
            wb_write_data     <= '0;
        end else begin
            wb_instruction    <= instruction;
            wb_write_register <= write_register;
            wb_write_address  <= write_address;
            wb_write_data     <= write_data;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-bus handshake, stall, timeout and error flags
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     mem_instruction,
    input  logic                      mem_shouldWriteRegister,
    input  logic [REG_ADDR_WIDTH-1:0] mem_registerWriteAddress,
    input  logic                      mem_shouldWriteMemoryElseAluOutputToRegister,
    input  logic [DATA_WIDTH-1:0]     mem_aluOutput,
    input  logic                      mem_shouldWriteMemory,
    input  logic [DATA_WIDTH-1:0]     mem_registerRtOrZero,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     wb_instruction,
    output logic                      wb_shouldWriteRegister,
    output logic [REG_ADDR_WIDTH-1:0] wb_registerWriteAddress,
    output logic [DATA_WIDTH-1:0]     wb_registerWriteData,
    output logic                      err_misaligned,
    output logic                      err_timeout
);
    localparam logic [WAIT_COUNT_WIDTH-1:0] TIMEOUT_LIMIT = WAIT_COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WAIT_COUNT_WIDTH-1:0] COUNT_MAX     = '1;

    state_t                      state;
    state_t                      state_next;
    logic [WAIT_COUNT_WIDTH-1:0] wait_count;
    logic                        load;
    logic                        store;
    logic                        access;
    logic                        misaligned;
    logic                        timeout;
    logic                        retire_write;
    logic [DATA_WIDTH-1:0]       write_data;

    assign load       = mem_shouldWriteRegister & mem_shouldWriteMemoryElseAluOutputToRegister;
    assign store      = mem_shouldWriteMemory;
    assign access     = load | store;
    assign misaligned = access & (mem_aluOutput[1:0] != 2'b00);

    assign dmem_we    = store;
    assign dmem_addr  = {mem_aluOutput[DATA_WIDTH-1:2], 2'b00};
    assign dmem_wdata = mem_registerRtOrZero;

    // An ack in the final counted cycle still wins over the abort.
    assign timeout = (state == WAIT) & ~dmem_ack & (wait_count == TIMEOUT_LIMIT);
    assign stall   = dmem_req & ~dmem_ack & ~timeout;

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = access & ~misaligned;
                if (dmem_req && !dmem_ack) state_next = WAIT;
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack || timeout) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Held at zero in IDLE so every entry to WAIT starts from a clean count.
    always_ff @(posedge clock) begin
        if (reset || state == IDLE)                 wait_count <= '0;
        else if (!dmem_ack && wait_count != COUNT_MAX) wait_count <= wait_count + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            err_misaligned <= err_misaligned | ((state == IDLE) & misaligned);
            err_timeout    <= err_timeout | timeout;
        end
    end

    assign retire_write = mem_shouldWriteRegister & ~misaligned & ~timeout;
    assign write_data   = load ? dmem_rdata : mem_aluOutput;

    mem_wb_register u_wb_register (
        .clock             (clock),
        .reset             (reset),
        .bubble            (stall),
        .instruction       (mem_instruction),
        .write_register    (retire_write),
        .write_address     (mem_registerWriteAddress),
        .write_data        (write_data),
        .wb_instruction    (wb_instruction),
        .wb_write_register (wb_shouldWriteRegister),
        .wb_write_address  (wb_registerWriteAddress),
        .wb_write_data     (wb_registerWriteData)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_instruction;
    logic        mem_shouldWriteRegister;
    logic [4:0]  mem_registerWriteAddress;
    logic        mem_shouldWriteMemoryElseAluOutputToRegister;
    logic [31:0] mem_aluOutput;
    logic        mem_shouldWriteMemory;
    logic [31:0] mem_registerRtOrZero;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] wb_instruction;
    logic        wb_shouldWriteRegister;
    logic [4:0]  wb_registerWriteAddress;
    logic [31:0] wb_registerWriteData;
    logic        err_misaligned;
    logic        err_timeout;

    typedef struct {
        logic [31:0] instr;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;

    mem_access_stage dut (
        .clock                                        (clock),
        .reset                                        (reset),
        .mem_instruction                              (mem_instruction),
        .mem_shouldWriteRegister                      (mem_shouldWriteRegister),
        .mem_registerWriteAddress                     (mem_registerWriteAddress),
        .mem_shouldWriteMemoryElseAluOutputToRegister (mem_shouldWriteMemoryElseAluOutputToRegister),
        .mem_aluOutput                                (mem_aluOutput),
        .mem_shouldWriteMemory                        (mem_shouldWriteMemory),
        .mem_registerRtOrZero                         (mem_registerRtOrZero),
        .dmem_req                                     (dmem_req),
        .dmem_we                                      (dmem_we),
        .dmem_addr                                    (dmem_addr),
        .dmem_wdata                                   (dmem_wdata),
        .dmem_ack                                     (dmem_ack),
        .dmem_rdata                                   (dmem_rdata),
        .stall                                        (stall),
        .wb_instruction                               (wb_instruction),
        .wb_shouldWriteRegister                       (wb_shouldWriteRegister),
        .wb_registerWriteAddress                      (wb_registerWriteAddress),
        .wb_registerWriteData                         (wb_registerWriteData),
        .err_misaligned                               (err_misaligned),
        .err_timeout                                  (err_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic wr, input logic [4:0] rd,
                         input logic wbsel, input logic [31:0] alu, input logic wmem,
                         input logic [31:0] rt);
        mem_instruction                              = instr;
        mem_shouldWriteRegister                      = wr;
        mem_registerWriteAddress                     = rd;
        mem_shouldWriteMemoryElseAluOutputToRegister = wbsel;
        mem_aluOutput                                = alu;
        mem_shouldWriteMemory                        = wmem;
        mem_registerRtOrZero                         = rt;
    endtask

    task automatic push(input logic [31:0] instr, input logic wr, input logic [4:0] rd,
                        input logic [31:0] data);
        wb_exp_t e;
        e.instr = instr;
        e.wr    = wr;
        e.rd    = rd;
        e.data  = data;
        sb.push_back(e);
    endtask

    // Advance one clock, then compare the WB register against the oldest expectation.
    task automatic tick(input string tag);
        wb_exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed %0h expected entry", tag, wb_instruction);
        end else begin
            e = sb.pop_front();
            check({tag, ".wb_instr"}, wb_instruction, e.instr);
            check({tag, ".wb_wr"}, 32'(wb_shouldWriteRegister), 32'(e.wr));
            check({tag, ".wb_rd"}, 32'(wb_registerWriteAddress), 32'(e.rd));
            check({tag, ".wb_data"}, wb_registerWriteData, e.data);
        end
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        push(32'h0, 1'b0, 5'd0, 32'h0);
        tick("reset");
        check("reset.err_mis", 32'(err_misaligned), 32'h0);
        check("reset.err_to", 32'(err_timeout), 32'h0);
        check("reset.req", 32'(dmem_req), 32'h0);
        check("reset.stall", 32'(stall), 32'h0);
        reset = 1'b0;

        drive(32'h1111_0001, 1'b1, 5'd5, 1'b0, 32'h1234, 1'b0, 32'h0);
        #1;
        check("alu.req", 32'(dmem_req), 32'h0);
        check("alu.stall", 32'(stall), 32'h0);
        push(32'h1111_0001, 1'b1, 5'd5, 32'h1234);
        tick("alu");

        drive(32'h2222_0002, 1'b1, 5'd6, 1'b1, 32'h100, 1'b0, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld0.req", 32'(dmem_req), 32'h1);
        check("ld0.addr", dmem_addr, 32'h100);
        check("ld0.we", 32'(dmem_we), 32'h0);
        check("ld0.stall", 32'(stall), 32'h0);
        push(32'h2222_0002, 1'b1, 5'd6, 32'hDEAD_BEEF);
        tick("ld0");
        dmem_ack = 1'b0;

        drive(32'h3333_0003, 1'b0, 5'd0, 1'b0, 32'h204, 1'b1, 32'hCAFE);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st.req", 32'(dmem_req), 32'h1);
            check("st.we", 32'(dmem_we), 32'h1);
            check("st.addr", dmem_addr, 32'h204);
            check("st.wdata", dmem_wdata, 32'hCAFE);
            check("st.stall", 32'(stall), 32'h1);
            push(32'h0, 1'b0, 5'd0, 32'h0);
            tick("st.wait");
        end
        dmem_ack = 1'b1;
        #1;
        check("st.ack_stall", 32'(stall), 32'h0);
        push(32'h3333_0003, 1'b0, 5'd0, 32'h204);
        tick("st.done");
        dmem_ack = 1'b0;

        drive(32'h4444_0004, 1'b1, 5'd7, 1'b1, 32'h102, 1'b0, 32'h0);
        dmem_rdata = 32'h0BAD;
        #1;
        check("mis.req", 32'(dmem_req), 32'h0);
        check("mis.stall", 32'(stall), 32'h0);
        push(32'h4444_0004, 1'b0, 5'd7, 32'h0BAD);
        tick("mis");
        check("mis.err_mis", 32'(err_misaligned), 32'h1);
        check("mis.err_to", 32'(err_timeout), 32'h0);

        drive(32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        dmem_ack = 1'b1;
        #1;
        check("idle_ack.req", 32'(dmem_req), 32'h0);
        check("idle_ack.stall", 32'(stall), 32'h0);
        push(32'h0, 1'b0, 5'd0, 32'h0);
        tick("idle_ack");
        dmem_ack = 1'b0;
        #1;
        check("idle_ack.still_idle", 32'(dmem_req), 32'h0);

        drive(32'h5555_0005, 1'b1, 5'd8, 1'b1, 32'h300, 1'b0, 32'h0);
        dmem_rdata = 32'h5A5A_5A5A;
        #1;
        check("to.issue_stall", 32'(stall), 32'h1);
        push(32'h0, 1'b0, 5'd0, 32'h0);
        tick("to.issue");
        for (int i = 0; i < 255; i++) begin
            #1;
            check("to.wait_stall", 32'(stall), 32'h1);
            push(32'h0, 1'b0, 5'd0, 32'h0);
            tick("to.wait");
        end
        #1;
        check("to.abort_stall", 32'(stall), 32'h0);
        check("to.abort_req", 32'(dmem_req), 32'h1);
        check("to.err_before", 32'(err_timeout), 32'h0);
        push(32'h5555_0005, 1'b0, 5'd8, 32'h5A5A_5A5A);
        tick("to.abort");
        check("to.err_to", 32'(err_timeout), 32'h1);
        check("to.err_mis_sticky", 32'(err_misaligned), 32'h1);
        drive(32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("to.back_idle", 32'(dmem_req), 32'h0);

        drive(32'h6666_0006, 1'b1, 5'd9, 1'b1, 32'h400, 1'b0, 32'h0);
        push(32'h0, 1'b0, 5'd0, 32'h0);
        tick("rw.issue");
        push(32'h0, 1'b0, 5'd0, 32'h0);
        tick("rw.wait");
        #1;
        check("rw.in_wait", 32'(stall), 32'h1);
        reset = 1'b1;
        drive(32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(32'h0, 1'b0, 5'd0, 32'h0);
        tick("rw.reset");
        reset = 1'b0;
        #1;
        check("rw.req", 32'(dmem_req), 32'h0);
        check("rw.stall", 32'(stall), 32'h0);
        check("rw.err_mis", 32'(err_misaligned), 32'h0);
        check("rw.err_to", 32'(err_timeout), 32'h0);

        drive(32'h7777_0007, 1'b1, 5'd3, 1'b0, 32'hABCD, 1'b0, 32'h0);
        push(32'h7777_0007, 1'b1, 5'd3, 32'hABCD);
        tick("post_reset_alu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
